// File: rtl/cpu_clk_gen.sv
// cpu_clk_gen: per-channel clock-enable strobe generator gated by a refclk settle counter.
// Define CPU_CLK_GEN_STEP_EN to add single-step control of channel 0 (run_mode/step_req).
module cpu_clk_gen #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DIV_INIT    = 50
) (
  input  logic                          refclk,
  input  logic                          rst_n,
  input  logic [CHANNELS*DIV_WIDTH-1:0] div_val,
  input  logic                          div_load,
  input  logic                          run_mode,
  input  logic                          step_req,
  output logic [CHANNELS-1:0]           ce_out,
  output logic                          locked
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_WIDTH-1:0] DINIT = DIV_WIDTH'(DIV_INIT);
  // Divisors 0 and 1 both reload to 0 so the strobe fires every cycle.
  function automatic logic [DIV_WIDTH-1:0] reload(input logic [DIV_WIDTH-1:0] d);
    return (d > DIV_WIDTH'(1)) ? d - DIV_WIDTH'(1) : '0;
  endfunction
  logic [LW-1:0]        lock_cnt_q, lock_cnt_d;
  logic                 locked_q, locked_d;
  logic [DIV_WIDTH-1:0] shadow_q [CHANNELS];
  logic [DIV_WIDTH-1:0] shadow_d [CHANNELS];
  logic [DIV_WIDTH-1:0] active_q [CHANNELS];
  logic [DIV_WIDTH-1:0] active_d [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_q [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]  term, ce_d, ce_q;
  always_comb begin
    lock_cnt_d = locked_q ? lock_cnt_q : lock_cnt_q + LW'(1);
    locked_d   = locked_q | (lock_cnt_d == LW'(LOCK_CYCLES));
  end
  // Until locked every channel keeps reloading, so a divisor loaded early becomes the first period.
  always_comb begin
    term = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      shadow_d[k] = div_load ? div_val[k*DIV_WIDTH +: DIV_WIDTH] : shadow_q[k];
      term[k]     = locked_q && (cnt_q[k] == '0);
      active_d[k] = (!locked_q || term[k]) ? shadow_d[k] : active_q[k];
      cnt_d[k]    = (!locked_q || term[k]) ? reload(active_d[k]) : cnt_q[k] - DIV_WIDTH'(1);
    end
  end
`ifdef CPU_CLK_GEN_STEP_EN
  logic step_prev_q, pend_q, pend_d;
  // A pending step is consumed by the next channel-0 terminal count; extra edges meanwhile are dropped.
  always_comb begin
    pend_d = run_mode ? 1'b0 : pend_q ? !term[0] : (step_req & !step_prev_q);
    ce_d    = term;
    ce_d[0] = term[0] & (run_mode | pend_q);
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      step_prev_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      step_prev_q <= step_req;
      pend_q      <= pend_d;
    end
`else
  logic unused_step;
  assign unused_step = run_mode ^ step_req;
  assign ce_d = term;
`endif
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      ce_q       <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= DINIT;
        active_q[k] <= DINIT;
        cnt_q[k]    <= reload(DINIT);
      end
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      ce_q       <= ce_d;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
    end
  assign ce_out = ce_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_cpu_clk_gen.sv
// tb_cpu_clk_gen: scoreboard bench; the reference model tracks absolute strobe times per channel.
module tb_cpu_clk_gen;
  localparam int CH = 2, DW = 16, LOCK = 16, DINIT = 50;
  logic refclk = 1'b0, rst_n = 1'b0, div_load = 1'b0, run_mode = 1'b1, step_req = 1'b0;
  logic [CH*DW-1:0] div_val = '0;
  logic [CH-1:0] ce_out;
  logic locked;
  cpu_clk_gen #(.CHANNELS(CH), .DIV_WIDTH(DW), .LOCK_CYCLES(LOCK), .DIV_INIT(DINIT)) dut (
    .refclk(refclk), .rst_n(rst_n), .div_val(div_val), .div_load(div_load),
    .run_mode(run_mode), .step_req(step_req), .ce_out(ce_out), .locked(locked)
  );
  always #5 refclk = ~refclk;
  int total = 0, bad = 0;
  logic [CH:0] exp_q[$];
  logic [CH:0] e;
  int t = 0, lc = 0;
  int sh[CH], nxt[CH];
  bit m_locked, m_pend, m_prev;
  logic [CH-1:0] m_ce;
  bit cnt_en = 0;
  int pulses = 0;
  function automatic int period(int d);
    return d < 1 ? 1 : d;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic model_reset();
    lc = 0; m_locked = 0; m_pend = 0; m_prev = 0; m_ce = '0;
    for (int k = 0; k < CH; k++) sh[k] = DINIT;
  endtask
  task automatic model_step();
    bit t0;
    t++;
    if (div_load) for (int k = 0; k < CH; k++) sh[k] = int'(div_val[k*DW +: DW]);
    m_ce = '0;
    if (!m_locked) begin
      lc++;
      if (lc == LOCK) begin
        m_locked = 1;
        for (int k = 0; k < CH; k++) nxt[k] = t + period(sh[k]);
      end
    end else begin
      for (int k = 0; k < CH; k++)
        if (t == nxt[k]) begin
          m_ce[k] = 1'b1;
          nxt[k] = t + period(sh[k]);
        end
    end
    t0 = m_ce[0];
`ifdef CPU_CLK_GEN_STEP_EN
    if (!run_mode && !m_pend) m_ce[0] = 1'b0;
    if (run_mode) m_pend = 0;
    else if (m_pend) begin
      if (t0) m_pend = 0;
    end else if (step_req && !m_prev) m_pend = 1;
    m_prev = step_req;
`endif
  endtask
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge refclk);
      model_step();
      exp_q.push_back({m_locked, m_ce});
      #2;
      div_load = 1'b0;
    end
  endtask
  task automatic set_div(int k, int v);
    div_val[k*DW +: DW] = DW'(v);
  endtask
  task automatic do_reset();
    @(negedge refclk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ce_out", 32'(ce_out), 0);
    check("rst_locked", 32'(locked), 0);
    model_reset();
    repeat (3) begin
      @(posedge refclk);
      exp_q.push_back('0);
      #2;
    end
    @(negedge refclk);
    #1 rst_n = 1'b1;
  endtask
  always @(negedge refclk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ce_out", 32'(ce_out), 32'(e[CH-1:0]));
      check("locked", 32'(locked), 32'(e[CH]));
    end
    if (cnt_en) pulses += int'(ce_out[0]);
  end
  initial begin
    for (int k = 0; k < CH; k++) set_div(k, DINIT);
    model_reset();
    do_reset();
    cyc(LOCK + 125);
    set_div(0, 10); set_div(1, 50); div_load = 1'b1;
    cyc(81);
    set_div(1, 0); div_load = 1'b1;
    cyc(61);
    set_div(1, 1); div_load = 1'b1;
    cyc(21);
    repeat (300) begin
      if ($urandom_range(15) == 0) begin
        for (int k = 0; k < CH; k++) set_div(k, int'($urandom_range(12)));
        div_load = 1'b1;
      end
`ifdef CPU_CLK_GEN_STEP_EN
      if ($urandom_range(31) == 0) run_mode = ~run_mode;
      if ($urandom_range(5) == 0) step_req = ~step_req;
`endif
      cyc(1);
    end
    for (int k = 0; k < CH; k++) set_div(k, 4);
    div_load = 1'b1; run_mode = 1'b1; step_req = 1'b0;
    cyc(10);
`ifdef CPU_CLK_GEN_STEP_EN
    run_mode = 1'b0;
    cyc(10);
    pulses = 0; cnt_en = 1;
    repeat (3) begin
      step_req = 1'b1; cyc(2);
      step_req = 1'b0; cyc(18);
    end
    cyc(5);
    cnt_en = 0;
    check("step_pulses", 32'(pulses), 3);
    step_req = 1'b1; cyc(1); step_req = 1'b0; cyc(1);
    step_req = 1'b1; cyc(1); step_req = 1'b0; cyc(12);
    step_req = 1'b1; cyc(1); step_req = 1'b0;
`else
    run_mode = 1'b0;
    cyc(10);
    pulses = 0; cnt_en = 1;
    cyc(40);
    cnt_en = 0;
    check("free_run_pulses", 32'(pulses), 10);
`endif
    do_reset();
    cyc(LOCK + 120);
    cyc(2);
    @(negedge refclk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
